rx_word_align: RTL and testbench
================================

# rx_word_align

Receive-side word aligner for the source-synchronous serial link driven by our OSERDESE3 + OBUFDS transmit path. It sits in the divided-clock domain behind the IBUFDS/ISERDESE3 pair and takes raw DATA_WIDTH-bit words that may be misaligned to the transmitter's word boundary. It performs fabric bitslip against a known training pattern, locks, then delivers aligned words with a valid strobe.

## Interface
- DATA_WIDTH, 4: word width. Only 4 and 8 are legal, matching the OSERDESE3 widths.
- TRAIN_PATTERN, 4'b0011: training word sent by the transmitter; DATA_WIDTH bits wide; all rotations must be distinct.
- MATCH_CNT, 16: number of consecutive matching beats required to lock.
- SLIP_WAIT, 2: beats discarded after reset, relock or a slip. Must be at least 2.

Ports:
- clk  in  1  divided clock (ISERDES CLKDIV domain).
- rst  in  1  synchronous, active-high reset.
- din  in  DATA_WIDTH  raw parallel word; din[0] is the earliest-received bit.
- din_valid  in  1  beat strobe; din is sampled only when this is 1.
- train_en  in  1  1 = the transmitter is currently sending TRAIN_PATTERN.
- relock  in  1  single-cycle request to restart alignment.
- dout  out  DATA_WIDTH  aligned word; dout[0] is the earliest bit.
- dout_valid  out  1  one pulse per aligned beat; only asserted while locked.
- locked  out  1  1 while the FSM is in LOCKED.
- slip_offset  out  $clog2(DATA_WIDTH)  current bit offset.
- align_err  out  1  sticky: a full sweep of offsets failed to lock.

## Operation
- History registers: on each beat, cur_q <= din and prev_q <= cur_q. The window is {cur_q, prev_q}, 2*DATA_WIDTH bits wide. The aligned word is window[slip_offset +: DATA_WIDTH].
- All comparisons and outputs at a beat edge use the window as it was held before that edge.
- FSM states: WAIT, SEARCH, SLIP, LOCKED.
  - WAIT: counts SLIP_WAIT beats, then moves to SEARCH. Reset and relock both enter WAIT.
  - SEARCH with train_en=0: hold state and clear match_cnt.
  - SEARCH with train_en=1, on a beat where the aligned word equals TRAIN_PATTERN: match_cnt++. When match_cnt reaches MATCH_CNT, move to LOCKED.
  - SEARCH with train_en=1, on a mismatch: clear match_cnt and go to SLIP.
  - SLIP: one clock, no beat needed. slip_offset <= (slip_offset+1) mod DATA_WIDTH, which wraps from DATA_WIDTH-1 to 0. slip_cnt increments and saturates. Then go to WAIT.
  - LOCKED: slip_offset is frozen. On every beat, dout <= aligned word and dout_valid <= 1. Payload is never checked.
- align_err: set when slip_cnt reaches 2*DATA_WIDTH without a lock. It stays set and search continues. It is cleared only by rst or relock.
- relock, from any state: next state is WAIT. slip_offset, match_cnt, slip_cnt and align_err are cleared. locked drops on the next edge.
- relock and din_valid in the same cycle: relock wins the FSM, but the beat is still shifted into the history registers.
- rst has priority over everything.
- Counter widths: match_cnt is $clog2(MATCH_CNT+1) bits; slip_cnt is $clog2(2*DATA_WIDTH+1) bits.

## Timing
- Reset values:
  - dout=0, dout_valid=0, locked=0, slip_offset=0, align_err=0.
  - cur_q=0, prev_q=0, all counters 0.
  - FSM in WAIT.
- Latency: a beat n in LOCKED outputs the window captured by beats n-1 and n-2. At offset 0, dout at beat n+1 equals din from beat n-1.
- dout_valid: registered, one clock high per beat edge in LOCKED, 0 otherwise. With continuous din_valid it is continuously high.
- Lock time with continuous beats from reset, d=0, MATCH_CNT=16:
  - Beats 1–2 are WAIT.
  - Beats 3–18 match.
  - locked=1 after the beat-18 edge; the first dout_valid is at beat 19.
- A transmit stream delayed by d bits locks at slip_offset=d.
- Each failed offset costs 1 SLIP clock plus SLIP_WAIT beats plus 1 compare beat.

## Structure
- Package rx_align_pkg holds:
  - state enum: WAIT, SEARCH, SLIP, LOCKED.
  - the legal DATA_WIDTH check as an elaboration assertion.
  - helper function for the counter width.
- Sub-module rx_bitslip_shift: combinational window select {cur_q, prev_q}[offset +: DATA_WIDTH]. It is shared with a future ISERDES-native bitslip variant.

## Test plan
- Reset, then continuous TRAIN_PATTERN=0011 with d=0 and train_en=1 → slip_offset=0, locked rises after beat 18, align_err=0.
- Stream delayed by d=1, then d=3 (DATA_WIDTH=4) → lock with slip_offset=1 and 3 respectively. Check the slip wrap 3→0 by starting a sweep at offset 3 via relock timing.
- Constant 0000 with train_en=1 → no lock. align_err=1 after 8 slips; slip_offset keeps cycling. Pulse relock → align_err=0, slip_offset=0.
- Lock, then send payload 4'hA,4'h5,4'hC → dout shows A,5,C two beats later with dout_valid high. Gap din_valid → dout_valid low for those beats.
- train_en=0 during SEARCH → no slips, match_cnt held at 0. Assert rst mid-LOCKED → all outputs return to reset values on the next edge.
- relock together with din_valid while LOCKED → locked=0 next edge, FSM in WAIT, beat still enters cur_q.

Source files
------------

// File: rtl/rx_align_pkg.sv
// rx_align_pkg: shared state type and elaboration helpers for the receive word aligner
package rx_align_pkg;

   typedef enum logic [1:0] {S_WAIT, S_SEARCH, S_SLIP, S_LOCKED} align_st_e;

   function automatic int cnt_w(input int max_val);
      return $clog2(max_val + 1);
   endfunction

   function automatic bit width_ok(input int w);
      return (w == 4) || (w == 8);
   endfunction

endpackage

// File: rtl/rx_bitslip_shift.sv
// rx_bitslip_shift: selects one word from the two-word history window at a bit offset
module rx_bitslip_shift
   import rx_align_pkg::*;
#(
   parameter int DATA_WIDTH = 4
) (
   input  logic [DATA_WIDTH-1:0]         cur_i,
   input  logic [DATA_WIDTH-1:0]         prev_i,
   input  logic [$clog2(DATA_WIDTH)-1:0] offset_i,
   output logic [DATA_WIDTH-1:0]         word_o
);

   logic [2*DATA_WIDTH-1:0] win;

   assign win    = {cur_i, prev_i};
   assign word_o = DATA_WIDTH'(win >> offset_i);

endmodule

// File: rtl/rx_word_align.sv
// rx_word_align: fabric bitslip aligner that locks onto a training word and then forwards aligned words
module rx_word_align
   import rx_align_pkg::*;
#(
   parameter int                    DATA_WIDTH    = 4,
   parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = 4'b0011,
   parameter int                    MATCH_CNT     = 16,
   parameter int                    SLIP_WAIT     = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_WIDTH-1:0]         din,
   input  logic                          din_valid,
   input  logic                          train_en,
   input  logic                          relock,
   output logic [DATA_WIDTH-1:0]         dout,
   output logic                          dout_valid,
   output logic                          locked,
   output logic [$clog2(DATA_WIDTH)-1:0] slip_offset,
   output logic                          align_err
);

   localparam int OW = $clog2(DATA_WIDTH);
   localparam int MW = cnt_w(MATCH_CNT);
   localparam int SW = cnt_w(2 * DATA_WIDTH);
   localparam int WW = cnt_w(SLIP_WAIT);
   localparam logic [MW-1:0] MATCH_LAST = MW'(MATCH_CNT - 1);
   localparam logic [SW-1:0] SLIP_MAX   = SW'(2 * DATA_WIDTH);
   localparam logic [WW-1:0] WAIT_LAST  = WW'(SLIP_WAIT - 1);

   if (!width_ok(DATA_WIDTH)) begin : g_bad_width
      $error("rx_word_align: DATA_WIDTH must be 4 or 8");
   end
   if (SLIP_WAIT < 2) begin : g_bad_wait
      $error("rx_word_align: SLIP_WAIT must be at least 2");
   end

   align_st_e             state_q, state_d;
   logic [DATA_WIDTH-1:0] cur_q, prev_q;
   logic [DATA_WIDTH-1:0] aligned;
   logic [WW-1:0]         wait_cnt_q, wait_cnt_d;
   logic [MW-1:0]         match_cnt_q, match_cnt_d;
   logic [SW-1:0]         slip_cnt_q, slip_cnt_d;
   logic [OW-1:0]         slip_off_q, slip_off_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  dv_q, dv_d;

   rx_bitslip_shift #(.DATA_WIDTH(DATA_WIDTH)) u_shift (
      .cur_i    (cur_q),
      .prev_i   (prev_q),
      .offset_i (slip_off_q),
      .word_o   (aligned)
   );

   // two-word history of raw beats; a relock beat still shifts in
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_q  <= '0;
         prev_q <= '0;
      end else if (din_valid) begin
         prev_q <= cur_q;
         cur_q  <= din;
      end
   end

   // alignment FSM: settle, compare, slip, then forward aligned words once locked
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      match_cnt_d = match_cnt_q;
      slip_cnt_d  = slip_cnt_q;
      slip_off_d  = slip_off_q;
      err_d       = err_q;
      dout_d      = dout_q;
      dv_d        = 1'b0;
      if (relock) begin
         state_d     = S_WAIT;
         wait_cnt_d  = '0;
         match_cnt_d = '0;
         slip_cnt_d  = '0;
         slip_off_d  = '0;
         err_d       = 1'b0;
      end else begin
         case (state_q)
            S_WAIT: begin
               if (din_valid) begin
                  wait_cnt_d = (wait_cnt_q == WAIT_LAST) ? '0 : wait_cnt_q + WW'(1);
                  state_d    = (wait_cnt_q == WAIT_LAST) ? S_SEARCH : S_WAIT;
               end
            end
            S_SEARCH: begin
               if (!train_en) begin
                  match_cnt_d = '0;
               end else if (din_valid) begin
                  if (aligned == TRAIN_PATTERN) begin
                     match_cnt_d = match_cnt_q + MW'(1);
                     state_d     = (match_cnt_q == MATCH_LAST) ? S_LOCKED : S_SEARCH;
                  end else begin
                     match_cnt_d = '0;
                     state_d     = S_SLIP;
                  end
               end
            end
            S_SLIP: begin
               slip_off_d = slip_off_q + OW'(1);
               slip_cnt_d = (slip_cnt_q == SLIP_MAX) ? slip_cnt_q : slip_cnt_q + SW'(1);
               err_d      = err_q | (slip_cnt_d == SLIP_MAX);
               state_d    = S_WAIT;
            end
            S_LOCKED: begin
               dout_d = din_valid ? aligned : dout_q;
               dv_d   = din_valid;
            end
            default: state_d = S_WAIT;
         endcase
      end
   end

   // state, counter and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_WAIT;
         wait_cnt_q  <= '0;
         match_cnt_q <= '0;
         slip_cnt_q  <= '0;
         slip_off_q  <= '0;
         err_q       <= 1'b0;
         dout_q      <= '0;
         dv_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         match_cnt_q <= match_cnt_d;
         slip_cnt_q  <= slip_cnt_d;
         slip_off_q  <= slip_off_d;
         err_q       <= err_d;
         dout_q      <= dout_d;
         dv_q        <= dv_d;
      end
   end

   assign dout        = dout_q;
   assign dout_valid  = dv_q;
   assign locked      = (state_q == S_LOCKED);
   assign slip_offset = slip_off_q;
   assign align_err   = err_q;

endmodule

// File: tb/tb_rx_word_align.sv
// tb_rx_word_align: randomized scoreboard bench for rx_word_align with a bit-stream reference model
module tb_rx_word_align;

   localparam int W  = 4;
   localparam int MC = 16;
   localparam int SW = 2;
   localparam logic [3:0] TP = 4'b0011;

   logic       clk, rst, din_valid, train_en, relock;
   logic [3:0] din, dout;
   logic       dout_valid, locked, align_err;
   logic [1:0] slip_offset;

   rx_word_align dut (
      .clk         (clk),
      .rst         (rst),
      .din         (din),
      .din_valid   (din_valid),
      .train_en    (train_en),
      .relock      (relock),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .locked      (locked),
      .slip_offset (slip_offset),
      .align_err   (align_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   bit mon_en = 0;

   // model: n = edges since reset/relock, tgt = stream delay (-1 never matches, -2 training off)
   int n   = 0;
   int tgt = -2;
   logic [3:0] tx_hist[$];
   logic [3:0] expq[$];
   logic [3:0] last_rx;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // each failed offset costs one slip clock, SLIP_WAIT beats and one compare beat
   function automatic int slips();
      int s;
      if (tgt == -2) return 0;
      s = n / (SW + 2);
      if (tgt >= 0 && s > tgt) s = tgt;
      return s;
   endfunction

   function automatic bit m_lock();
      return tgt >= 0 && n >= SW + tgt * (SW + 2) + MC;
   endfunction

   // receive word of a tx stream delayed by d bits
   function automatic logic [3:0] mk(input logic [3:0] c, input logic [3:0] p, input int d);
      logic [7:0] w;
      w = {c, p};
      w = w >> (W - d);
      return w[3:0];
   endfunction

   task automatic cyc(input bit r, input bit rl, input bit v, input bit tr,
                      input logic [3:0] tx, input int d, input int nt);
      logic [3:0] rx;
      rx = mk(tx, tx_hist[$], d);
      rst = r; relock = rl; din_valid = v; train_en = tr; din = rx;
      last_rx = rx;
      if (!r && !rl && v && m_lock()) expq.push_back(tx_hist[$-1]);
      @(posedge clk);
      #1;
      if (r || rl) begin
         tgt = nt;
         n   = 0;
      end else n++;
      if (r) begin
         tx_hist.delete();
         tx_hist.push_back(4'h0);
         tx_hist.push_back(4'h0);
      end else if (v) tx_hist.push_back(tx);
      @(negedge clk);
      #1;
   endtask

   task automatic train(input int k, input logic [3:0] tx, input int d, input bit tr);
      for (int i = 0; i < k; i++) cyc(0, 0, 1'b1, tr, tx, d, tgt);
   endtask

   task automatic payload(input int k, input int d);
      for (int i = 0; i < k; i++)
         cyc(0, 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom), d, tgt);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         logic [3:0] e;
         bit ev;
         ev = expq.size() > 0;
         chk("dout_valid", dout_valid, ev);
         if (ev) begin
            e = expq.pop_front();
            if (dout_valid) chk("dout", dout, e);
         end
         chk("locked", locked, m_lock());
         chk("slip_offset", slip_offset, slips() % W);
         chk("align_err", align_err, slips() >= 2 * W);
      end
   end

   initial begin
      rst = 1'b1; relock = 1'b0; din = '0; din_valid = 1'b0; train_en = 1'b0;
      tx_hist.push_back(4'h0);
      tx_hist.push_back(4'h0);
      cyc(1, 0, 0, 0, 4'h0, 0, 0);
      mon_en = 1;
      cyc(1, 0, 0, 0, 4'h0, 0, 0);
      chk("reset dout", dout, 0);
      chk("reset cur_q", dut.cur_q, 0);
      chk("reset prev_q", dut.prev_q, 0);
      train(25, TP, 0, 1);
      cyc(0, 0, 1, 1, 4'hA, 0, tgt);
      cyc(0, 0, 1, 1, 4'h5, 0, tgt);
      cyc(0, 0, 1, 1, 4'hC, 0, tgt);
      cyc(0, 0, 0, 1, 4'h0, 0, tgt);
      cyc(0, 0, 0, 1, 4'h0, 0, tgt);
      cyc(0, 0, 1, 1, 4'h7, 0, tgt);
      payload(30, 0);
      cyc(0, 1, 1, 1, TP, 1, 1);
      chk("relock beat in cur_q", dut.cur_q, last_rx);
      train(30, TP, 1, 1);
      payload(20, 1);
      cyc(0, 1, 1, 1, TP, 3, 3);
      train(40, TP, 3, 1);
      payload(20, 3);
      cyc(0, 1, 1, 1, 4'h0, 0, -1);
      train(45, 4'h0, 0, 1);
      cyc(0, 1, 1, 0, TP, 2, -2);
      train(20, TP, 2, 0);
      chk("match_cnt held", dut.match_cnt_q, 0);
      cyc(0, 1, 1, 1, TP, 2, 2);
      train(36, TP, 2, 1);
      payload(10, 2);
      cyc(1, 0, 1, 1, 4'($urandom), 2, -2);
      chk("mid-lock reset dout", dout, 0);
      chk("mid-lock reset cur_q", dut.cur_q, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 4'h0, 0, tgt);
      chk("scoreboard drained", expq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
